// File: rtl/lcd_fifo_pkg.sv
// lcd_fifo_pkg: shared defaults and types for the LCD pixel FIFO.
//   LCD_FIFO_W  - default pixel word width
//   LCD_FIFO_D  - default entry count
//   LCD_FIFO_WM - default watermark threshold (register-block reset value)
package lcd_fifo_pkg;

  localparam int LCD_FIFO_W  = 32;
  localparam int LCD_FIFO_D  = 32;
  localparam int LCD_FIFO_WM = 28;

  typedef logic [LCD_FIFO_W-1:0] pixel_word_t;

endpackage

// File: rtl/lcd_fifo_ram.sv
// lcd_fifo_ram: DEPTH x DATA_W storage, one synchronous write port and one
// synchronous read port whose output register is the FIFO's data_out.
//   clk_i     - clock
//   rst_i     - synchronous active-high reset (clears the read register only)
//   wr_en_i   - write strobe
//   wr_addr_i - write address
//   wr_data_i - write data
//   rd_en_i   - read strobe; read register holds when low
//   rd_addr_i - read address
//   rd_data_o - registered read data
module lcd_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset; occupancy is tracked by the pointers, so
  // stale contents are never observable and the array can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // A read and write to the same slot (full FIFO, simultaneous access)
  // returns the old word: the oldest entry leaves as the new one lands.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lcd_pixel_fifo.sv
// lcd_pixel_fifo: single-clock pixel FIFO between the AHB DMA fetch path and
// the LCD serialiser, flushed by v_sync at every frame boundary.
//   HCLK, HRESET    - clock, synchronous active-high reset
//   v_sync          - frame flush (drops contents, overrides wr/rd)
//   wr_en, data_in  - write request and data
//   rd_en, stopin   - read request and read stall
//   wm_level        - watermark threshold (values above DEPTH act as DEPTH)
//   clr_err         - clears sticky overflow/underflow
//   data_out        - registered read data, valid with data_valid pulse
//   fifo_empty/full/watermark, level - occupancy status
//   overflow, underflow - sticky error flags
module lcd_pixel_fifo
  import lcd_fifo_pkg::*;
#(
  parameter int DATA_W   = LCD_FIFO_W,
  parameter int DEPTH    = LCD_FIFO_D,
  parameter int AW       = $clog2(DEPTH),
  parameter int WM_RESET = LCD_FIFO_WM
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              v_sync,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic              stopin,
  input  logic [AW:0]       wm_level,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_watermark,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              underflow
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AW != $clog2(DEPTH) ||
      WM_RESET > DEPTH) begin : g_bad_param
    $error("lcd_pixel_fifo: illegal DEPTH/AW/WM_RESET");
  end

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          data_valid_q, data_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc, rd_go, wr_go;
  logic [AW:0]   wm_eff;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == DEPTH_L);

  // A read at full frees a slot, so the write in the same cycle still fits.
  assign rd_acc = rd_en & ~stopin & ~fifo_empty;
  assign wr_acc = wr_en & (~fifo_full | rd_acc);

  // Flush wins over any transfer in the same cycle.
  assign rd_go = rd_acc & ~v_sync;
  assign wr_go = wr_acc & ~v_sync;

  assign wm_eff         = (wm_level > DEPTH_L) ? DEPTH_L : wm_level;
  assign fifo_watermark = (level_q >= wm_eff);

  // NOTE: every next-state variable gets a default before any branch so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_valid_d = rd_go;
    if (v_sync) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_go) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW+1)'(wr_go) - (AW+1)'(rd_go);
    end
    // Set beats clear when both happen in one cycle.
    overflow_d  = (wr_en & fifo_full & ~rd_acc & ~v_sync) | (overflow_q & ~clr_err);
    underflow_d = (rd_en & ~stopin & fifo_empty & ~v_sync) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  lcd_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i     (HCLK),
    .rst_i     (HRESET),
    .wr_en_i   (wr_go),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_go),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign data_valid = data_valid_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_lcd_pixel_fifo.sv
module tb_lcd_pixel_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              v_sync;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              stopin;
  logic [AW:0]       wm_level;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_watermark;
  logic [AW:0]       level;
  logic              overflow;
  logic              underflow;

  int checks   = 0;
  int failures = 0;

  lcd_pixel_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .WM_RESET (28)
  ) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .v_sync         (v_sync),
    .wr_en          (wr_en),
    .data_in        (data_in),
    .rd_en          (rd_en),
    .stopin         (stopin),
    .wm_level       (wm_level),
    .clr_err        (clr_err),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_watermark (fifo_watermark),
    .level          (level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after
  // the rising edge, inputs return to idle afterwards.
  task automatic cyc(input logic wr, input logic [DATA_W-1:0] din, input logic rd,
                     input logic stop = 1'b0, input logic vs = 1'b0,
                     input logic clr = 1'b0, input logic rst = 1'b0);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    stopin  = stop;
    v_sync  = vs;
    clr_err = clr;
    HRESET  = rst;
    @(posedge HCLK);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    stopin  = 1'b0;
    v_sync  = 1'b0;
    clr_err = 1'b0;
    HRESET  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [DATA_W-1:0] exp);
    cyc(1'b0, '0, 1'b1);
    check({tag, "_valid"}, 64'(data_valid), 64'd1);
    check({tag, "_data"}, 64'(data_out), 64'(exp));
  endtask

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_w;
  int                n_wr;
  int                c;
  logic              do_wr, do_rd;

  initial begin
    HRESET = 1'b1; v_sync = 1'b0; wr_en = 1'b0; data_in = '0;
    rd_en = 1'b0; stopin = 1'b0; wm_level = 6'd28; clr_err = 1'b0;
    @(posedge HCLK); #1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(fifo_empty), 64'd1);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_wm", 64'(fifo_watermark), 64'd0);
    check("rst_dout", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_flags", 64'({overflow, underflow}), 64'd0);
    wm_level = 6'd0; #1;
    check("rst_wm0", 64'(fifo_watermark), 64'd1);
    wm_level = 6'd28;

    // 1. Fill / drain ordering
    for (int i = 1; i <= 32; i++) cyc(1'b1, DATA_W'(i), 1'b0);
    check("t1_full", 64'(fifo_full), 64'd1);
    check("t1_level", 64'(level), 64'd32);
    check("t1_wr_no_valid", 64'(data_valid), 64'd0);
    for (int i = 1; i <= 32; i++) rd_check("t1_rd", DATA_W'(i));
    cyc(1'b0, '0, 1'b0);
    check("t1_valid_pulse", 64'(data_valid), 64'd0);
    check("t1_empty", 64'(fifo_empty), 64'd1);
    check("t1_flags", 64'({overflow, underflow}), 64'd0);

    // 2. Watermark
    for (int i = 0; i < 27; i++) cyc(1'b1, DATA_W'(100 + i), 1'b0);
    check("t2_wm_27", 64'(fifo_watermark), 64'd0);
    cyc(1'b1, DATA_W'(127), 1'b0);
    check("t2_wm_28", 64'(fifo_watermark), 64'd1);
    wm_level = 6'd10; #1;
    check("t2_wm_lvl10", 64'(fifo_watermark), 64'd1);
    for (int i = 0; i < 18; i++) rd_check("t2_rd", DATA_W'(100 + i));
    check("t2_level10", 64'(level), 64'd10);
    check("t2_wm_at10", 64'(fifo_watermark), 64'd1);
    rd_check("t2_rd", DATA_W'(118));
    check("t2_wm_at9", 64'(fifo_watermark), 64'd0);
    for (int i = 119; i <= 127; i++) rd_check("t2_drain", DATA_W'(i));
    check("t2_empty", 64'(fifo_empty), 64'd1);
    wm_level = 6'd28;

    // 3. Overflow and simultaneous access at full
    for (int i = 0; i < 32; i++) cyc(1'b1, DATA_W'(200 + i), 1'b0);
    check("t3_full", 64'(fifo_full), 64'd1);
    wm_level = 6'd40; #1;
    check("t3_wm_clamp", 64'(fifo_watermark), 64'd1);
    wm_level = 6'd28;
    cyc(1'b1, 32'hDEAD, 1'b0);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_ovf_level", 64'(level), 64'd32);
    cyc(1'b1, 32'hBEEF, 1'b1);
    check("t3_rw_level", 64'(level), 64'd32);
    check("t3_rw_valid", 64'(data_valid), 64'd1);
    check("t3_rw_data", 64'(data_out), 64'd200);
    for (int i = 201; i <= 231; i++) rd_check("t3_rd", DATA_W'(i));
    rd_check("t3_last", 32'hBEEF);
    check("t3_empty", 64'(fifo_empty), 64'd1);
    check("t3_unf", 64'(underflow), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_clr", 64'(overflow), 64'd0);

    // 4. Underflow and stall
    cyc(1'b0, '0, 1'b1);
    check("t4_unf", 64'(underflow), 64'd1);
    check("t4_unf_valid", 64'(data_valid), 64'd0);
    check("t4_unf_level", 64'(level), 64'd0);
    cyc(1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      check("t4_stall_level", 64'(level), 64'd1);
      check("t4_stall_valid", 64'(data_valid), 64'd0);
    end
    rd_check("t4_rd", 32'h55);
    check("t4_level0", 64'(level), 64'd0);
    // Set in the same cycle as the clear keeps the flag
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_set_wins", 64'(underflow), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_clr", 64'({overflow, underflow}), 64'd0);

    // 5. Flush
    cyc(1'b0, '0, 1'b1);
    check("t5_unf_pre", 64'(underflow), 64'd1);
    for (int i = 0; i < 10; i++) cyc(1'b1, DATA_W'(300 + i), 1'b0);
    check("t5_level10", 64'(level), 64'd10);
    cyc(1'b1, 32'hAAAA, 1'b1, 1'b0, 1'b1);
    check("t5_level", 64'(level), 64'd0);
    check("t5_valid", 64'(data_valid), 64'd0);
    check("t5_dout_hold", 64'(data_out), 64'h55);
    check("t5_flags", 64'({overflow, underflow}), 64'b01);
    cyc(1'b1, 32'h1234, 1'b0);
    rd_check("t5_new", 32'h1234);
    check("t5_empty", 64'(fifo_empty), 64'd1);

    // 6. Wrap at 3 writes : 2 reads, then reset mid-operation
    n_wr = 0;
    c    = 0;
    while (n_wr < 100) begin
      do_wr = (c % 5) < 3;
      do_rd = (((c % 5) >= 3) || (sb_q.size() >= 24)) && (sb_q.size() > 0);
      exp_w = '0;
      if (do_rd) exp_w = sb_q.pop_front();
      if (do_wr) begin
        sb_q.push_back(DATA_W'(32'h1000 + n_wr));
        n_wr++;
      end
      cyc(do_wr, DATA_W'(32'h1000 + n_wr - (do_wr ? 1 : 0)), do_rd);
      if (do_rd) check("t6_stream", 64'(data_out), 64'(exp_w));
      c++;
    end
    check("t6_level", 64'(level), 64'(sb_q.size()));
    while (sb_q.size() > 12) rd_check("t6_drain", sb_q.pop_front());
    check("t6_level12", 64'(level), 64'd12);
    check("t6_unf_pre", 64'(underflow), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_dout", 64'(data_out), 64'd0);
    check("t6_rst_valid", 64'(data_valid), 64'd0);
    check("t6_rst_flags", 64'({overflow, underflow}), 64'd0);
    check("t6_rst_empty", 64'(fifo_empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_fifo.md
Name: lcd_pixel_fifo

Overview:
- Parametrised, single-clock pixel FIFO between the AHB DMA fetch path and the LCD pixel serialiser.
- Successor to the fixed 32x32 frame FIFO, with these differences:
  - storage is internal rather than an external memory interface;
  - width and depth are parameters;
  - the watermark threshold is programmable at run time;
  - full/overflow/underflow are reported, with sticky error flags;
  - read is a registered, one-cycle-latency handshake instead of an edge-triggered read.
- v_sync flushes the FIFO at every frame boundary.

Parameters:
- DATA_W, 32, pixel/word width in bits.
- DEPTH, 32, entry count; must be a power of two, at least 4.
- AW, $clog2(DEPTH), pointer width (derived; do not override).
- WM_RESET, 28, default watermark threshold, loaded into no register (documentation only; wm_level is driven by the register block).

Ports:
- HCLK  in  1  system clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- v_sync  in  1  frame flush; synchronous and level-sensitive.
- wr_en  in  1  write request from the DMA side.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request from the serialiser.
- stopin  in  1  read stall; while high, rd_en is ignored.
- wm_level  in  AW+1  watermark threshold, 0..DEPTH.
- clr_err  in  1  clears the sticky error flags.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  one-cycle pulse: data_out updated this cycle.
- fifo_empty  out  1  level == 0.
- fifo_full  out  1  level == DEPTH.
- fifo_watermark  out  1  level >= wm_level.
- level  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was made while empty.

Behaviour:

Reset and flush
- Reset (HRESET=1 at an edge) clears: wr_ptr, rd_ptr, level, data_out, data_valid, overflow, underflow.
  - Resulting flags: fifo_empty=1, fifo_full=0.
  - fifo_watermark = (wm_level==0).
- Reset mid-operation drops all stored data. Memory contents need not be cleared.
- Flush (v_sync=1 at an edge, HRESET=0):
  - clears wr_ptr, rd_ptr, level and data_valid;
  - data_out holds its value;
  - sticky flags are unchanged.
- v_sync overrides any wr_en/rd_en in the same cycle: nothing is written or read.

Handshake
- rd_acc = rd_en & ~stopin & ~fifo_empty.
- wr_acc = wr_en & (~fifo_full | rd_acc).
  - When full, a simultaneous read frees a slot and the write is accepted.

Write
- On wr_acc: mem[wr_ptr] <= data_in, then wr_ptr <= wr_ptr+1.

Read
- On rd_acc: data_out <= mem[rd_ptr], then rd_ptr <= rd_ptr+1.
- data_valid=1 in the cycle after acceptance (latency 1).
- data_out holds its value when there is no read.

Read-while-write
- When empty, a same-cycle write is not readable; the read is not accepted.
- The earliest read of a word is the cycle after its write.

Pointers and level
- Pointers are AW bits and wrap modulo DEPTH naturally.
- level <= level + wr_acc - rd_acc, saturating impossible by construction.
- Flags are combinational from the level register.

Error flags
- overflow sets on wr_en & fifo_full & ~rd_acc & ~v_sync.
- underflow sets on rd_en & ~stopin & fifo_empty & ~v_sync.
- clr_err clears both flags. A set event in the same cycle wins over the clear.

Watermark
- wm_level may change at any time; the flag tracks it combinationally.
- wm_level > DEPTH is treated as DEPTH.

Decomposition:
- Package lcd_fifo_pkg holds:
  - localparam defaults (LCD_FIFO_W=32, LCD_FIFO_D=32, LCD_FIFO_WM=28);
  - typedef logic [LCD_FIFO_W-1:0] pixel_word_t.
- Sub-module lcd_fifo_ram: DEPTH x DATA_W storage with one synchronous write port and one synchronous registered read port.
  - It provides the data_out register.
- Pointer, level and flag logic stays in lcd_pixel_fifo.

Test Plan:
1. Fill/drain ordering:
   - Stimulus: write 0x00000001..0x00000020 (32 words), then read 32 times.
   - Required: fifo_full=1 after the 32nd write; data_out returns 1..0x20 in order, each with data_valid one cycle after rd_en; fifo_empty=1 at the end; no error flags.
2. Watermark:
   - Stimulus: wm_level=28; write 27 words, then 1 more; then wm_level=10 with level=28; then read 18 words.
   - Required: watermark=0 at level 27 and 1 at level 28; stays 1 after wm_level=10; clears at level 9.
3. Overflow and simultaneous access at full:
   - Stimulus: when full, wr_en alone with data 0xDEAD; next cycle wr_en+rd_en with data 0xBEEF.
   - Required: the first write is dropped and overflow=1; the second write is accepted and level stays 32; 0xBEEF is the last word read out.
4. Underflow and stall:
   - Stimulus: when empty, rd_en=1.
   - Required: underflow=1 and no data_valid.
   - Stimulus: then write 1 word; hold rd_en=1 with stopin=1 for 3 cycles.
   - Required: level stays 1; the word is read when stopin drops.
   - Stimulus: clr_err pulse.
   - Required: flags=0.
5. Flush:
   - Stimulus: write 10 words; assert v_sync together with wr_en and rd_en for one cycle.
   - Required: level=0 next cycle; no data_valid; overflow/underflow unchanged; the next write/read returns the new word.
6. Wrap and reset mid-operation:
   - Stimulus: stream 100 words at a 3-write:2-read ratio; then assert HRESET at level 12.
   - Required: data stays in order across pointer wrap; after reset, level=0, data_out=0, data_valid=0 and sticky flags=0.
